// File: rtl/gen_lane_shuffle_pipe_if.sv
// Streaming bus for the lane shuffle pipe: producer-side beat with mode,
// consumer-side transformed beat, and the completed-transfer count.
interface gen_lane_shuffle_pipe_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned W = LANES * LANE_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] xfer_count;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, xfer_count
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, xfer_count
  );
endinterface

// File: rtl/gen_lane_shuffle_pipe.sv
// Elastic lane/bit shuffle: per-beat mode selects a reordering of the input
// word, and the result flows through STAGES valid/ready register stages.
module gen_lane_shuffle_pipe #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  gen_lane_shuffle_pipe_if.slave  bus
);
  localparam int unsigned W = LANES * LANE_W;

  logic [W-1:0] t_inv;
  logic [W-1:0] t_lrev;
  logic [W-1:0] t_brev;
  logic [W-1:0] t_frev;
  logic [W-1:0] t_mir;
  logic [W-1:0] xf_c;

  assign t_inv = ~bus.in_data;

  // Lane-granular and in-lane bit permutations
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    for (genvar b = 0; b < LANE_W; b++) begin : g_bit
      assign t_lrev[k*LANE_W + b] = bus.in_data[(LANES-1-k)*LANE_W + b];
      assign t_brev[k*LANE_W + b] = bus.in_data[k*LANE_W + (LANE_W-1-b)];
    end
  end

  // Whole-word permutations; odd W leaves the middle bit in place for mirror
  for (genvar i = 0; i < W; i++) begin : g_word
    assign t_frev[i] = bus.in_data[W-1-i];
    if (i < W/2) begin : g_lo
      assign t_mir[i] = bus.in_data[i];
    end else begin : g_hi
      assign t_mir[i] = bus.in_data[W-1-i];
    end
  end

  always_comb begin
    xf_c = bus.in_data;
    case (bus.in_mode)
      3'd1:    xf_c = t_inv;
      3'd2:    xf_c = t_lrev;
      3'd3:    xf_c = t_brev;
      3'd4:    xf_c = t_frev;
      3'd5:    xf_c = t_mir;
      default: xf_c = bus.in_data;
    endcase
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] up_vld;
  logic [W-1:0]      dat    [STAGES];
  logic [W-1:0]      up_dat [STAGES];
  logic [CNT_W-1:0]  cnt;

  // Ready ripples back from the consumer; a stage is free if empty or draining
  always_comb begin
    rdy = '0;
    rdy[STAGES-1] = !vld[STAGES-1] | bus.out_ready;
    for (int s = int'(STAGES) - 2; s >= 0; s--) begin
      rdy[s] = !vld[s] | rdy[s+1];
    end
  end

  always_comb begin
    up_vld    = '0;
    up_vld[0] = bus.in_valid;
    up_dat[0] = xf_c;
    for (int s = 1; s < int'(STAGES); s++) begin
      up_vld[s] = vld[s-1];
      up_dat[s] = dat[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int s = 0; s < int'(STAGES); s++) begin
        dat[s] <= '0;
      end
    end else begin
      for (int s = 0; s < int'(STAGES); s++) begin
        if (rdy[s]) begin
          vld[s] <= up_vld[s];
          if (up_vld[s]) begin
            dat[s] <= up_dat[s];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (vld[STAGES-1] && bus.out_ready) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready   = rdy[0];
  assign bus.out_valid  = vld[STAGES-1];
  assign bus.out_data   = dat[STAGES-1];
  assign bus.xfer_count = cnt;
endmodule

// File: tb/tb_gen_lane_shuffle_pipe.sv
// Directed and streaming checks for gen_lane_shuffle_pipe at 4x8 bits, 2 stages.
module tb_gen_lane_shuffle_pipe;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;

  logic [31:0] exp_mode [8];

  always #5 clk = ~clk;

  gen_lane_shuffle_pipe_if #(.LANES(4), .LANE_W(8), .CNT_W(16)) bus ();

  gen_lane_shuffle_pipe #(.LANES(4), .LANE_W(8), .STAGES(2), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] model(input logic [31:0] d, input logic [2:0] m);
    logic [31:0] r;
    r = d;
    case (m)
      3'd1: r = ~d;
      3'd2: for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(3-k) +: 8];
      3'd3: for (int k = 0; k < 4; k++) for (int b = 0; b < 8; b++) r[8*k+b] = d[8*k+7-b];
      3'd4: for (int i = 0; i < 32; i++) r[i] = d[31-i];
      3'd5: for (int i = 16; i < 32; i++) r[i] = d[31-i];
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=00000000", bus.out_data); end
    total++; if (bus.xfer_count !== 16'h0) begin bad++; $display("FAIL reset_xfer_count got=%0d exp=0", bus.xfer_count); end
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_modes();
    for (int m = 0; m < 8; m++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0123_4567;
      bus.in_mode  = 3'(m);
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mode%0d_in_ready got=%b exp=1", m, bus.in_ready); end
      @(negedge clk);
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mode%0d_early_valid got=%b exp=0", m, bus.out_valid); end
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_mode[m]) begin
        bad++; $display("FAIL mode%0d_out got valid=%b data=%h exp valid=1 data=%h", m, bus.out_valid, bus.out_data, exp_mode[m]);
      end
    end
    exp_cnt += 8;
    @(negedge clk);
    total++; if (bus.xfer_count !== 16'(exp_cnt)) begin bad++; $display("FAIL modes_count got=%0d exp=%0d", bus.xfer_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 12;
    for (int t = 0; t < N + 2; t++) begin
      @(negedge clk);
      if (t >= 2) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_mode[(t-2) % 6]) begin
          bad++; $display("FAIL b2b_beat%0d got valid=%b data=%h exp valid=1 data=%h", t-2, bus.out_valid, bus.out_data, exp_mode[(t-2) % 6]);
        end
      end
      if (t < N) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0123_4567;
        bus.in_mode  = 3'(t % 6);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready%0d got=%b exp=1", t, bus.in_ready); end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    exp_cnt += N;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
    total++; if (bus.xfer_count !== 16'(exp_cnt)) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", bus.xfer_count, exp_cnt); end
  endtask

  task automatic test_stall();
    logic [31:0] d [3];
    d[0] = 32'hA0A0_0001; d[1] = 32'hB1B1_0002; d[2] = 32'hC2C2_0003;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_mode   = 3'd0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      #1;
      total++;
      if (bus.in_ready !== (i < 2)) begin bad++; $display("FAIL stall_in_ready%0d got=%b exp=%b", i, bus.in_ready, (i < 2)); end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== d[0]) begin
        bad++; $display("FAIL stall_hold%0d got rdy=%b vld=%b data=%h exp rdy=0 vld=1 data=%h", i, bus.in_ready, bus.out_valid, bus.out_data, d[0]);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_full_accept got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== d[i]) begin
        bad++; $display("FAIL stall_drain%0d got vld=%b data=%h exp vld=1 data=%h", i, bus.out_valid, bus.out_data, d[i]);
      end
      @(negedge clk);
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_no_dup got=%b exp=0", bus.out_valid); end
    exp_cnt += 3;
    total++; if (bus.xfer_count !== 16'(exp_cnt)) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", bus.xfer_count, exp_cnt); end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b0;
    bus.in_mode   = 3'd1;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h5555_0000 + 32'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL midrst_loaded got=%b exp=1", bus.out_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL midrst_out_data got=%h exp=00000000", bus.out_data); end
    total++; if (bus.xfer_count !== 16'h0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", bus.xfer_count); end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale%0d got=%b exp=0", i, bus.out_valid); end
    end
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic [31:0] d;
    logic [31:0] e;
    logic [2:0]  m;
    logic        iv;
    logic        ordy;
    int sent = 0;
    int rcvd = 0;
    int cyc  = 0;
    while (rcvd < 70000 && cyc < 90000) begin
      @(negedge clk);
      cyc++;
      if (sent < 4000) begin
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 2) != 0);
      end else begin
        iv   = 1'b1;
        ordy = ($urandom_range(0, 63) != 0);
      end
      if (sent >= 70000) iv = 1'b0;
      d = $urandom;
      m = 3'($urandom_range(0, 7));
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.in_mode   = m;
      bus.out_ready = ordy;
      #1;
      if (iv && bus.in_ready) begin
        q.push_back(model(d, m));
        sent++;
      end
      if (bus.out_valid && ordy) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_spurious beat=%0d got=%h exp=none", rcvd, bus.out_data);
        end else begin
          e = q.pop_front();
          if (bus.out_data !== e) begin bad++; $display("FAIL rand_data beat=%0d got=%h exp=%h", rcvd, bus.out_data, e); end
        end
        rcvd++;
      end
    end
    bus.in_valid = 1'b0;
    total++;
    if (rcvd < 70000) begin bad++; $display("FAIL rand_timeout got=%0d beats exp=70000", rcvd); end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d exp=0", q.size()); end
    @(negedge clk);
    total++; if (bus.xfer_count !== 16'd4464) begin bad++; $display("FAIL rand_wrap_count got=%0d exp=4464", bus.xfer_count); end
  endtask

  initial begin
    exp_mode[0] = 32'h0123_4567;
    exp_mode[1] = 32'hFEDC_BA98;
    exp_mode[2] = 32'h6745_2301;
    exp_mode[3] = 32'h80C4_A2E6;
    exp_mode[4] = 32'hE6A2_C480;
    exp_mode[5] = 32'hE6A2_4567;
    exp_mode[6] = 32'h0123_4567;
    exp_mode[7] = 32'h0123_4567;
    test_reset();
    test_modes();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
